// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory arbiter: owner tag, FSM states,
// the latched request record and the one-hot access sizes.
package main_mem_pkg;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int WORD_W  = 32;

  localparam logic [2:0] SIZE_W = 3'b100;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_B = 3'b001;

  // Encoded to match the memory response tag (lsu_aL_ifu_aH).
  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IFU = 1'b1
  } mem_owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Fixed-priority pick (LSU first) with an IFU starvation guard; owns starve_cnt.
// Requests are only accepted while the arbiter is idle.
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic idle,
  input  logic ifu_req_valid,
  input  logic ifu_flush,
  input  logic lsu_req_valid,
  output logic ifu_req_ready,
  output logic lsu_req_ready,
  output logic ifu_grant,
  output logic lsu_grant
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_ifu;
  logic          lsu_win;

  assign force_ifu     = ifu_req_valid && (starve_cnt == CW'(STARVE_LIMIT));
  assign lsu_win       = lsu_req_valid && !force_ifu;
  assign lsu_req_ready = idle && lsu_win;
  // A flushed IFU request is never accepted; a forced IFU under flush simply waits.
  assign ifu_req_ready = idle && ifu_req_valid && !ifu_flush && !lsu_win;
  assign lsu_grant     = lsu_req_ready;
  assign ifu_grant     = ifu_req_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      starve_cnt <= '0;
    end else if (ifu_grant) begin
      starve_cnt <= '0;
    end else if (lsu_grant && ifu_req_valid && (starve_cnt != CW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares the single main-memory port between IFU block refills and LSU loads/stores,
// one transaction in flight, routing read data back to its owner.
module main_mem_arbiter
  import main_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int BLOCK_WIDTH  = BLOCK_W,
  parameter int WORD_WIDTH   = WORD_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic                   ifu_req_valid,
  output logic                   ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  ifu_req_addr,
  input  logic                   ifu_flush,
  output logic                   ifu_resp_valid,
  output logic [BLOCK_WIDTH-1:0] ifu_resp_data,
  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_we,
  input  logic [ADDR_WIDTH-1:0]  lsu_req_addr,
  input  logic [2:0]             lsu_req_size,
  input  logic [WORD_WIDTH-1:0]  lsu_req_wdata,
  output logic                   lsu_st_done,
  output logic                   lsu_resp_valid,
  output logic [WORD_WIDTH-1:0]  lsu_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [2:0]             mem_req_size,
  output logic [WORD_WIDTH-1:0]  mem_req_wdata,
  input  logic                   mem_resp_valid,
  input  logic                   mem_resp_lsu_aL_ifu_aH,
  input  logic [BLOCK_WIDTH-1:0] mem_resp_data,
  output logic                   owner_err,
  output arb_state_e             dbg_state
);

  // Handshake rule: a request transfers on a cycle where *_req_valid && *_req_ready
  // at the rising clock edge; mem_req_* is held stable until mem_req_ready.

  arb_state_e state_q, state_d;
  mem_owner_e owner_q;
  mem_req_t   req_q;
  logic       drop_q;
  logic       ifu_grant, lsu_grant;

  mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk           (clk),
    .rst_aL        (rst_aL),
    .idle          (state_q == IDLE),
    .ifu_req_valid (ifu_req_valid),
    .ifu_flush     (ifu_flush),
    .lsu_req_valid (lsu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .lsu_req_ready (lsu_req_ready),
    .ifu_grant     (ifu_grant),
    .lsu_grant     (lsu_grant)
  );

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ifu_grant || lsu_grant) state_d = ISSUE;
      ISSUE:   if (mem_req_ready) state_d = req_q.we ? IDLE : WAIT;
      WAIT:    if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      owner_q        <= OWN_LSU;
      req_q          <= '0;
      drop_q         <= 1'b0;
      owner_err      <= 1'b0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= '0;
      lsu_st_done    <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_st_done    <= 1'b0;
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (lsu_grant) begin
            owner_q     <= OWN_LSU;
            req_q.we    <= lsu_req_we;
            req_q.addr  <= lsu_req_addr;
            req_q.size  <= lsu_req_size;
            req_q.wdata <= lsu_req_wdata;
          end else if (ifu_grant) begin
            owner_q     <= OWN_IFU;
            req_q.we    <= 1'b0;
            req_q.addr  <= ifu_req_addr;
            req_q.size  <= SIZE_W;
            req_q.wdata <= '0;
          end
        end
        ISSUE: begin
          if (owner_q == OWN_IFU && ifu_flush) drop_q <= 1'b1;
          if (mem_req_ready && req_q.we) lsu_st_done <= 1'b1;
        end
        WAIT: begin
          if (owner_q == OWN_IFU && ifu_flush) drop_q <= 1'b1;
          if (mem_resp_valid) begin
            // A wrong tag is flagged but the data still goes to the recorded owner.
            if (mem_owner_e'(mem_resp_lsu_aL_ifu_aH) != owner_q) owner_err <= 1'b1;
            if (owner_q == OWN_LSU) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= mem_resp_data[WORD_WIDTH-1:0];
            end else if (!drop_q && !ifu_flush) begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_data  <= mem_resp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_size  = req_q.size;
  assign mem_req_wdata = req_q.wdata;
  assign dbg_state     = state_q;

  a_lsu_size_onehot: assert property (@(posedge clk) disable iff (!rst_aL)
    lsu_req_valid |-> $onehot(lsu_req_size));

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Randomized and directed bench for main_mem_arbiter against a transaction-level
// reference model with response scoreboards.
module tb_main_mem_arbiter;
  import main_mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk, rst_aL;
  logic        ifu_req_valid, ifu_req_ready, ifu_flush, ifu_resp_valid;
  logic [31:0] ifu_req_addr;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_st_done, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [2:0]  lsu_req_size;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [2:0]  mem_req_size;
  logic        mem_resp_valid, mem_resp_lsu_aL_ifu_aH;
  logic [63:0] mem_resp_data;
  logic        owner_err;
  arb_state_e  dbg_state;

  main_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_flush(ifu_flush), .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_size(lsu_req_size), .lsu_req_wdata(lsu_req_wdata),
    .lsu_st_done(lsu_st_done), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_lsu_aL_ifu_aH(mem_resp_lsu_aL_ifu_aH),
    .mem_resp_data(mem_resp_data), .owner_err(owner_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: one transaction record plus expected next-cycle pulses
  bit          m_busy, m_acc, m_drop, m_err, m_own_ifu;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  int          m_starve;
  bit          e_ifu_v, e_lsu_v, e_st, g_ifu, g_lsu;
  logic [63:0] exp_q[$];
  logic [31:0] exp_lsu_q[$];
  int          rdy_pct = 100, wrong_pct = 0, dly_min = 0, dly_max = 0, resp_dly = 0;
  bit          force_resp = 0;
  int          ifu_resps = 0, lsu_resps = 0, st_pulses = 0;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_drop = 0; m_err = 0; m_starve = 0;
    e_ifu_v = 0; e_lsu_v = 0; e_st = 0; g_ifu = 0; g_lsu = 0; resp_dly = 0;
    exp_q.delete(); exp_lsu_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_aL = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_flush = 0;
    lsu_req_valid = 0; lsu_req_we = 0; lsu_req_addr = 0; lsu_req_size = SIZE_W; lsu_req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_lsu_aL_ifu_aH = 0; mem_resp_data = 0;
    #1;
    check("rst_state_idle", dbg_state == IDLE, 1'b1);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
    check("rst_pulses", {ifu_resp_valid, lsu_resp_valid, lsu_st_done}, 0);
    check("rst_data", {ifu_resp_data, lsu_resp_data} == 0, 1'b1);
    check("rst_owner_err", owner_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_aL = 1'b1;
    model_reset();
  endtask

  // memory-side driver
  task automatic drive_mem();
    mem_resp_valid = 0;
    mem_resp_lsu_aL_ifu_aH = 1'($urandom_range(0, 1));
    mem_resp_data = {$urandom, $urandom};
    mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    if (force_resp) begin
      mem_resp_valid = 1;
    end else if (m_busy && m_acc) begin
      if (resp_dly == 0) begin
        mem_resp_valid = 1;
        mem_resp_lsu_aL_ifu_aH = m_own_ifu ^ ($urandom_range(0, 99) < wrong_pct);
      end else resp_dly--;
    end
  endtask

  // one clock: check grants, advance model, check registered outputs
  task automatic step();
    bit lsu_pick, e_lg, e_ig;
    logic [63:0] d;
    drive_mem();
    #1;
    lsu_pick = lsu_req_valid && !(ifu_req_valid && m_starve == LIMIT);
    e_lg = !m_busy && lsu_pick;
    e_ig = !m_busy && ifu_req_valid && !ifu_flush && !lsu_pick;
    check("lsu_req_ready", lsu_req_ready, e_lg);
    check("ifu_req_ready", ifu_req_ready, e_ig);
    g_lsu = e_lg; g_ifu = e_ig;
    e_st = 0; e_ifu_v = 0; e_lsu_v = 0;
    if (m_busy) begin
      if (m_own_ifu && ifu_flush) m_drop = 1;
      if (!m_acc) begin
        if (mem_req_ready) begin
          if (m_we) begin e_st = 1; m_busy = 0; end
          else begin m_acc = 1; resp_dly = $urandom_range(dly_min, dly_max); end
        end
      end else if (mem_resp_valid) begin
        if (mem_resp_lsu_aL_ifu_aH != m_own_ifu) m_err = 1;
        if (!m_own_ifu) begin e_lsu_v = 1; exp_lsu_q.push_back(mem_resp_data[31:0]); end
        else if (!m_drop) begin e_ifu_v = 1; exp_q.push_back(mem_resp_data); end
        m_busy = 0;
      end
    end else if (e_lg) begin
      m_busy = 1; m_acc = 0; m_drop = 0; m_own_ifu = 0;
      m_we = lsu_req_we; m_addr = lsu_req_addr; m_size = lsu_req_size; m_wdata = lsu_req_wdata;
      if (ifu_req_valid && m_starve < LIMIT) m_starve++;
    end else if (e_ig) begin
      m_busy = 1; m_acc = 0; m_drop = 0; m_own_ifu = 1;
      m_we = 0; m_addr = ifu_req_addr; m_size = SIZE_W; m_wdata = 0;
      m_starve = 0;
    end
    @(negedge clk);
    if (g_lsu) lsu_req_valid = 0;
    if (g_ifu) ifu_req_valid = 0;
    check("state_idle", dbg_state == IDLE, !m_busy);
    check("mem_req_valid", mem_req_valid, m_busy && !m_acc);
    if (m_busy && !m_acc) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_we", mem_req_we, m_we);
      check("mem_req_size", mem_req_size, m_size);
      if (m_we) check("mem_req_wdata", mem_req_wdata, m_wdata);
    end
    check("lsu_st_done", lsu_st_done, e_st);
    check("ifu_resp_valid", ifu_resp_valid, e_ifu_v);
    check("lsu_resp_valid", lsu_resp_valid, e_lsu_v);
    if (e_ifu_v) begin
      d = exp_q.pop_front();
      if (ifu_resp_valid) check("ifu_resp_data", ifu_resp_data, d);
    end
    if (e_lsu_v) begin
      d = {32'b0, exp_lsu_q.pop_front()};
      if (lsu_resp_valid) check("lsu_resp_data", lsu_resp_data, d);
    end
    check("owner_err", owner_err, m_err);
    if (ifu_resp_valid) ifu_resps++;
    if (lsu_resp_valid) lsu_resps++;
    if (lsu_st_done) st_pulses++;
  endtask

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    step();
    while (m_busy && n < max_cycles) begin step(); n++; end
    repeat (2) step();
  endtask

  task automatic lsu_load(input logic [31:0] addr);
    lsu_req_valid = 1; lsu_req_we = 0; lsu_req_addr = addr; lsu_req_size = SIZE_W;
    lsu_req_wdata = $urandom;
  endtask

  function automatic logic [2:0] rand_size();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? SIZE_B : (r == 1) ? SIZE_H : SIZE_W;
  endfunction

  initial begin
    int wins, guard;
    bit ifu_done;
    rst_aL = 1'b1;
    do_reset();

    // 1: IFU-only refill
    rdy_pct = 100; dly_min = 1; dly_max = 1; ifu_resps = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h100;
    run_idle(20);
    check("t1_ifu_pulses", ifu_resps, 1);

    // 2: starvation guard
    dly_min = 0; dly_max = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h200;
    wins = 0; ifu_done = 0; guard = 0;
    while (!ifu_done && guard < 100) begin
      if (!lsu_req_valid) lsu_load($urandom & 32'hffff_fffc);
      step();
      if (g_lsu) wins++;
      if (g_ifu) ifu_done = 1;
      guard++;
    end
    check("t2_ifu_granted", ifu_done, 1'b1);
    check("t2_lsu_wins", wins, LIMIT);
    lsu_req_valid = 0;
    run_idle(20);
    ifu_req_valid = 1; lsu_load(32'h40);
    guard = 0;
    step();
    while (!g_lsu && !g_ifu && guard < 20) begin step(); guard++; end
    check("t2_lsu_first_again", g_lsu, 1'b1);
    run_idle(20); run_idle(20);

    // 3: store with stalled memory
    st_pulses = 0;
    lsu_req_valid = 1; lsu_req_we = 1; lsu_req_addr = 32'h20; lsu_req_size = SIZE_W;
    lsu_req_wdata = 32'hDEADBEEF;
    step();
    rdy_pct = 0; repeat (3) step();
    rdy_pct = 100; run_idle(10);
    check("t3_st_pulses", st_pulses, 1);

    // 4: flush while waiting, then flush coinciding with the response
    ifu_resps = 0; lsu_resps = 0; dly_min = 4; dly_max = 4;
    ifu_req_valid = 1; ifu_req_addr = 32'h300;
    step(); step();
    ifu_flush = 1; step(); ifu_flush = 0;
    run_idle(20);
    dly_min = 0; dly_max = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h340;
    step(); step();
    ifu_flush = 1; step(); ifu_flush = 0;
    run_idle(20);
    check("t4_ifu_dropped", ifu_resps, 0);
    lsu_load(32'h80);
    run_idle(20);
    check("t4_lsu_after_flush", lsu_resps, 1);

    // random traffic
    wrong_pct = 2; dly_min = 0; dly_max = 3;
    for (int i = 0; i < 2000; i++) begin
      rdy_pct = $urandom_range(30, 100);
      if (!ifu_req_valid && $urandom_range(0, 99) < 30) begin
        ifu_req_valid = 1; ifu_req_addr = $urandom & 32'hffff_fff8;
      end
      if (!lsu_req_valid && $urandom_range(0, 99) < 40) begin
        lsu_req_valid = 1; lsu_req_we = 1'($urandom_range(0, 1));
        lsu_req_addr = $urandom; lsu_req_size = rand_size(); lsu_req_wdata = $urandom;
      end
      ifu_flush = ($urandom_range(0, 99) < 6);
      step();
      ifu_flush = 0;
    end
    ifu_req_valid = 0; lsu_req_valid = 0; rdy_pct = 100;
    run_idle(20);

    // 5: wrong owner tag on an LSU load
    do_reset();
    wrong_pct = 100; lsu_resps = 0; dly_min = 1; dly_max = 1;
    lsu_load(32'hC0);
    run_idle(20);
    check("t5_owner_err", owner_err, 1'b1);
    check("t5_lsu_pulses", lsu_resps, 1);
    wrong_pct = 0;
    lsu_load(32'hC4);
    run_idle(20);

    // 6: reset while waiting, stale response afterwards
    do_reset();
    ifu_resps = 0; dly_min = 6; dly_max = 6;
    ifu_req_valid = 1; ifu_req_addr = 32'h400;
    step(); step(); step();
    do_reset();
    force_resp = 1; step(); force_resp = 0;
    repeat (2) step();
    check("t6_no_err", owner_err, 1'b0);
    check("t6_no_ifu_resp", ifu_resps, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
